// File: rtl/avalon_chan_fifo_bank.sv
// Avalon-MM write front end feeding per-channel FIFOs, drained by a
// round-robin arbiter into one registered, channel-tagged output stream.
module avalon_chan_fifo_bank #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_chan
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [DATA_W-1:0] drop   [NUM_CH];
    logic [CH_W-1:0]   last_grant;

    logic              wr_acc;
    logic              rd_acc;
    logic              load;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_ch;
    logic [NUM_CH-1:0] flush;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] accept;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] rd_word;

    assign wr_acc = chipselect & write;
    assign rd_acc = chipselect & read;
    assign load   = !out_valid || out_ready;

    always_comb begin
        flush = '0;
        push  = '0;
        full  = '0;
        elig  = '0;
        if (wr_acc && address == '0)
            flush = writedata[NUM_CH-1:0];
        for (int c = 0; c < NUM_CH; c++) begin
            full[c] = (cnt[c] == CNT_W'(DEPTH));
            push[c] = wr_acc && (address == ADDR_W'(c + 1));
            elig[c] = (cnt[c] != '0) && !flush[c];
        end
    end

    // Search starts one past the last granted channel, wrapping once.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(last_grant) + 1 + i;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        pop       = '0;
        accept    = '0;
        head_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c]    = load && gnt_found && (gnt_ch == CH_W'(c));
            accept[c] = push[c] && !flush[c] && (!full[c] || pop[c]);
            if (gnt_ch == CH_W'(c))
                head_data = mem[c][rd_ptr[c]];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (address == '0)
                rd_word[c] = (cnt[c] == '0);
            else if (address == ADDR_W'(c + 1))
                rd_word = drop[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (accept[c])
                mem[c][wr_ptr[c]] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
                drop[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    cnt[c]    <= '0;
                end else begin
                    if (accept[c])
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (pop[c])
                        rd_ptr[c] <= rd_ptr[c] + 1'b1;
                    cnt[c] <= cnt[c] + CNT_W'(accept[c])
                                     - CNT_W'(pop[c]);
                end
                // Flush-discarded pushes are not drops.
                if (push[c] && !flush[c] && full[c] && !pop[c]
                    && drop[c] != '1)
                    drop[c] <= drop[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            if (gnt_found) begin
                out_valid  <= 1'b1;
                out_data   <= head_data;
                out_chan   <= gnt_ch;
                last_grant <= gnt_ch;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_acc)
            readdata <= rd_word;
    end

endmodule

// File: tb/tb_avalon_chan_fifo_bank.sv
// Bench for avalon_chan_fifo_bank: queue-based reference model plus a
// scoreboard monitor, directed scenarios then randomized traffic.
module tb_avalon_chan_fifo_bank;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;
    localparam int CH_W   = 2;
    localparam int DMAX   = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_chan;

    avalon_chan_fifo_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect),
        .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(readdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] d;
    } out_t;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [DATA_W-1:0] mq [NUM_CH][$];
    int                mdrop [NUM_CH];
    int                mlast = NUM_CH - 1;
    logic              mvalid = 1'b0;
    logic [DATA_W-1:0] mrd = '0;
    out_t              exp_out [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain queues, evaluated on each rising edge.
    always @(posedge clk) begin
        logic [NUM_CH-1:0] fm;
        logic [DATA_W-1:0] v;
        int k;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mq[c].delete();
                mdrop[c] = 0;
            end
            mvalid = 1'b0;
            mrd    = '0;
            mlast  = NUM_CH - 1;
            exp_out.delete();
        end else begin
            fm = '0;
            if (chipselect && read) begin
                if (address == 0) begin
                    v = '0;
                    for (int c = 0; c < NUM_CH; c++)
                        v[c] = (mq[c].size() == 0);
                    mrd = v;
                end else if (int'(address) <= NUM_CH)
                    mrd = DATA_W'(mdrop[int'(address) - 1]);
                else
                    mrd = '0;
            end
            if (chipselect && write && address == 0)
                fm = writedata[NUM_CH-1:0];
            if (!mvalid || out_ready) begin
                mvalid = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    k = (mlast + 1 + i) % NUM_CH;
                    if (!mvalid && mq[k].size() > 0 && !fm[k]) begin
                        exp_out.push_back('{ch: CH_W'(k),
                                            d: mq[k].pop_front()});
                        mlast  = k;
                        mvalid = 1'b1;
                    end
                end
            end
            if (chipselect && write && address != 0
                && int'(address) <= NUM_CH) begin
                k = int'(address) - 1;
                if (!fm[k]) begin
                    if (mq[k].size() < DEPTH)
                        mq[k].push_back(writedata);
                    else if (mdrop[k] < DMAX)
                        mdrop[k]++;
                end
            end
            for (int c = 0; c < NUM_CH; c++)
                if (fm[c])
                    mq[c].delete();
        end
    end

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(mvalid));
            chk("readdata", 32'(readdata), 32'(mrd));
            if (out_valid) begin
                if (exp_out.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %0h ch %0d want none",
                             out_data, out_chan);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_out[0].d));
                    chk("out_chan", 32'(out_chan), 32'(exp_out[0].ch));
                    if (out_ready)
                        void'(exp_out.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
    endtask

    task automatic do_wr(input int a, input int d);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = ADDR_W'(a);
        writedata  = DATA_W'(d);
        tick();
        idle();
    endtask

    task automatic do_rd(input int a);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = ADDR_W'(a);
        tick();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int seq [6] = '{0, 1, 2, 0, 1, 2};
        logic [DATA_W-1:0] sd;
        logic [CH_W-1:0]   sc;
        reset = 1'b1;
        idle();
        address   = '0;
        writedata = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_chan", 32'(out_chan), 0);
        chk("rst_rdata", 32'(readdata), 0);
        mon_en = 1'b1;

        // single word latency and empty flags
        out_ready = 1'b1;
        do_wr(1, 'h11);
        do_rd(0);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 'h11);
        chk("lat_chan", 32'(out_chan), 0);
        chk("lat_flags", 32'(readdata), 'h06);
        tick();
        chk("lat_idle", 32'(out_valid), 0);

        // fill ch1 with backpressure, overflow once, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            do_wr(2, 'hA0 + i);
        do_rd(2);
        chk("ovf_drop", 32'(readdata), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_data", 32'(out_data), 32'('hA0 + i));
            chk("drain_chan", 32'(out_chan), 1);
            tick();
        end
        chk("drain_idle", 32'(out_valid), 0);

        // round robin across three loaded channels
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            do_wr(c + 1, 'hB0 + 2 * c);
            do_wr(c + 1, 'hB1 + 2 * c);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_chan", 32'(out_chan), 32'(seq[i]));
            tick();
        end

        // flush ch1 while its head sits in the output register
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            do_wr(2, 'hC0 + i);
        do_wr(0, 'h02);
        do_rd(0);
        chk("flush_flag", 32'(readdata[1]), 1);
        chk("flush_keep", 32'(out_data), 'hC0);
        do_rd(2);
        chk("flush_nodrop", 32'(readdata), 1);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("flush_idle", 32'(out_valid), 0);

        // long stall, then reset mid-stream
        out_ready = 1'b0;
        do_wr(1, 'hD0);
        tick();
        sd = out_data;
        sc = out_chan;
        for (int i = 0; i < 10; i++)
            do_wr(2 + (i % 2), 'hE0 + i);
        chk("stall_data", 32'(out_data), 32'(sd));
        chk("stall_chan", 32'(out_chan), 32'(sc));
        chk("stall_val", 32'(sd), 'hD0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_data", 32'(out_data), 0);
        chk("mid_chan", 32'(out_chan), 0);
        do_rd(0);
        chk("mid_flags", 32'(readdata), 'h07);

        // drop counter saturation
        for (int i = 0; i < 305; i++)
            do_wr(3, i);
        do_rd(3);
        chk("sat_drop", 32'(readdata), 'hFF);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            chipselect = ($urandom_range(0, 3) != 0);
            write      = $urandom_range(0, 1);
            read       = $urandom_range(0, 1);
            address    = ADDR_W'($urandom_range(0, 7));
            writedata  = DATA_W'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b0;
        idle();
        out_ready = 1'b1;
        repeat (20) tick();
        chk("final_empty", 32'(exp_out.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
